// File: rtl/vdevice_multi.sv
// vdevice_multi: N-channel button press counter with a fixed measurement window.
//
// After start, rising edges on each btn line are counted for DURATION seconds
// (TICKS_PER_SECOND clock cycles each), then the counts freeze and the winning
// channel is reported until reset returns the block to idle.
//
// Ports:
//   clk           system clock, all state on the rising edge
//   async_nreset  asynchronous active-low reset
//   start         begin a measurement (idle only)
//   reset         synchronous return to idle (counting / result)
//   btn           synchronised, debounced button levels, one per channel
//   counts        channel i at [i*CNT_WIDTH +: CNT_WIDTH]; zero unless in result
//   winner        lowest-index channel holding the maximum; zero unless in result
//   tie           two or more channels share the maximum; zero unless in result
//   busy          high while counting
//   done          high while in result
//   seconds_left  remaining seconds while counting, DURATION in idle, 0 in result
//
// State table (vdevice_multi FSM):
//   state    | meaning
//   IDLE     | waiting for start, outputs blank, seconds_left = DURATION
//   COUNTING | window open, edges increment the press counters
//   RESULT   | counters frozen, counts/winner/tie shown

// Load/increment register used for each press counter. Load has priority.
module vdevice_press_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             async_nreset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             incr,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (incr) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

module vdevice_multi #(
    parameter int N_CHANNELS       = 3,
    parameter int CNT_WIDTH        = 8,
    parameter int TICKS_PER_SECOND = 50_000_000,
    parameter int DURATION         = 10
) (
    input  logic                             clk,
    input  logic                             async_nreset,
    input  logic                             start,
    input  logic                             reset,
    input  logic [N_CHANNELS-1:0]            btn,
    output logic [N_CHANNELS*CNT_WIDTH-1:0]  counts,
    output logic [$clog2(N_CHANNELS)-1:0]    winner,
    output logic                             tie,
    output logic                             busy,
    output logic                             done,
    output logic [7:0]                       seconds_left
);

    localparam int WIN_W  = $clog2(N_CHANNELS);
    localparam int TICK_W = $clog2(TICKS_PER_SECOND);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        RESULT   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [TICK_W-1:0]                  tick_q;
    logic [7:0]                         sec_q;
    logic [N_CHANNELS-1:0]              btn_prev;
    logic [N_CHANNELS-1:0]              btn_rise;
    logic [N_CHANNELS-1:0]              cnt_incr;
    logic [N_CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q;
    logic                               cnt_load;
    logic                               tick_wrap;
    logic                               last_cycle;

    logic [CNT_WIDTH-1:0] max_val;
    logic [WIN_W-1:0]     best;
    logic                 seen;
    logic                 multi;

    assign tick_wrap  = (tick_q == TICK_W'(TICKS_PER_SECOND - 1));
    assign last_cycle = tick_wrap && (sec_q == 8'(DURATION - 1));
    assign btn_rise   = btn & ~btn_prev;
    assign cnt_load   = (state_q == IDLE) && start;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = COUNTING;
            end
            COUNTING: begin
                if (reset)           state_d = IDLE;
                else if (last_cycle) state_d = RESULT;
            end
            RESULT: begin
                if (reset) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- timebase ----------------
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            tick_q <= '0;
            sec_q  <= '0;
        end else if (cnt_load) begin
            tick_q <= '0;
            sec_q  <= '0;
        end else if (state_q == COUNTING) begin
            if (tick_wrap) begin
                tick_q <= '0;
                sec_q  <= sec_q + 8'd1;
            end else begin
                tick_q <= tick_q + TICK_W'(1);
            end
        end
    end

    // btn_prev tracks btn in every state so a button held across start
    // produces no edge until it is released and pressed again.
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            btn_prev <= '0;
        end else begin
            btn_prev <= btn;
        end
    end

    // ---------------- press counters ----------------
    // Saturation is enforced here: incr is withheld once a counter is all ones.
    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
        assign cnt_incr[i] = (state_q == COUNTING) && !reset && btn_rise[i] && !(&cnt_q[i]);

        vdevice_press_reg #(.WIDTH(CNT_WIDTH)) u_cnt (
            .clk          (clk),
            .async_nreset (async_nreset),
            .load         (cnt_load),
            .d            ('0),
            .incr         (cnt_incr[i]),
            .q            (cnt_q[i])
        );

        assign counts[i*CNT_WIDTH +: CNT_WIDTH] = (state_q == RESULT) ? cnt_q[i] : '0;
    end

    // ---------------- winner / tie ----------------
    // Strict greater-than keeps the lowest index on equal counts.
    always_comb begin
        max_val = '0;
        best    = '0;
        seen    = 1'b0;
        multi   = 1'b0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (cnt_q[i] > max_val) begin
                max_val = cnt_q[i];
                best    = WIN_W'(i);
            end
        end
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (cnt_q[i] == max_val) begin
                multi = multi | seen;
                seen  = 1'b1;
            end
        end
    end

    assign winner = (state_q == RESULT) ? best : '0;
    assign tie    = (state_q == RESULT) && multi;
    assign busy   = (state_q == COUNTING);
    assign done   = (state_q == RESULT);

    always_comb begin
        seconds_left = 8'd0;
        case (state_q)
            IDLE:     seconds_left = 8'(DURATION);
            COUNTING: seconds_left = 8'(DURATION) - sec_q;
            default:  seconds_left = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_vdevice_multi.sv
module tb_vdevice_multi;

    logic        clk = 1'b0;
    logic        async_nreset;
    logic        start;
    logic        reset;
    logic [2:0]  btn;

    logic [11:0] counts4;
    logic [1:0]  winner4;
    logic        tie4, busy4, done4;
    logic [7:0]  sl4;

    logic [5:0]  counts2;
    logic [1:0]  winner2;
    logic        tie2, busy2, done2;
    logic [7:0]  sl2;

    int n_cmp = 0;
    int n_err = 0;
    int win_id = 0;

    always #5 clk = ~clk;

    vdevice_multi #(.N_CHANNELS(3), .CNT_WIDTH(4), .TICKS_PER_SECOND(4), .DURATION(3)) dut4 (
        .clk(clk), .async_nreset(async_nreset), .start(start), .reset(reset), .btn(btn),
        .counts(counts4), .winner(winner4), .tie(tie4), .busy(busy4), .done(done4),
        .seconds_left(sl4)
    );

    vdevice_multi #(.N_CHANNELS(3), .CNT_WIDTH(2), .TICKS_PER_SECOND(4), .DURATION(3)) dut2 (
        .clk(clk), .async_nreset(async_nreset), .start(start), .reset(reset), .btn(btn),
        .counts(counts2), .winner(winner2), .tie(tie2), .busy(busy2), .done(done2),
        .seconds_left(sl2)
    );

    typedef struct {
        logic [2:0]  pre;
        logic [35:0] seq;
        logic        with_rst;
        logic [11:0] c4;
        logic [1:0]  w4;
        logic        t4;
        logic [5:0]  c2;
        logic [1:0]  w2;
        logic        t2;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [35:0] pk(input logic [2:0] a0, a1, a2, a3, a4, a5,
                                       input logic [2:0] a6, a7, a8, a9, a10, a11);
        return {a11, a10, a9, a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s (window %0d): got %0d, expected %0d", nm, win_id, act, exp);
        end
    endtask

    // Reference: count rising transitions, clamp to counter range, pick the
    // first maximum, flag a tie when the maximum appears more than once.
    task automatic model(input logic [2:0] pre, input logic [35:0] seq, input int width,
                         output logic [11:0] c, output logic [1:0] w, output logic t);
        int n[3];
        int cap, mx, hits;
        logic [2:0] prev, cur;
        cap = (1 << width) - 1;
        n = '{0, 0, 0};
        prev = pre;
        for (int k = 0; k < 12; k++) begin
            cur = seq[k*3 +: 3];
            for (int i = 0; i < 3; i++)
                if (cur[i] && !prev[i]) n[i]++;
            prev = cur;
        end
        c = '0;
        mx = 0;
        for (int i = 0; i < 3; i++) begin
            if (n[i] > cap) n[i] = cap;
            c[i*4 +: 4] = 4'(n[i]);
            if (n[i] > mx) mx = n[i];
        end
        w = 2'd0;
        hits = 0;
        for (int i = 2; i >= 0; i--)
            if (n[i] == mx) begin
                w = 2'(i);
                hits++;
            end
        t = (hits >= 2);
    endtask

    function automatic logic [5:0] narrow(input logic [11:0] c);
        return {c[9:8], c[5:4], c[1:0]};
    endfunction

    // Starts a window, plays 12 btn vectors, leaves the DUTs in RESULT.
    task automatic run_window(input vec_t v);
        btn   = v.pre;
        tick();
        start = 1'b1;
        reset = v.with_rst;
        tick();
        start = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("busy_in_window", busy4, 1);
            chk("seconds_left", sl4, 3 - k / 4);
            btn = v.seq[k*3 +: 3];
            tick();
        end
        btn = 3'b000;
        chk("done_at_end", done4, 1);
        chk("busy_at_end", busy4, 0);
        chk("seconds_left_result", sl4, 0);
        chk("counts_w4", counts4, v.c4);
        chk("winner_w4", winner4, v.w4);
        chk("tie_w4", tie4, v.t4);
        chk("done_w2", done2, 1);
        chk("counts_w2", counts2, v.c2);
        chk("winner_w2", winner2, v.w2);
        chk("tie_w2", tie2, v.t2);
    endtask

    // start in RESULT is ignored; reset returns to IDLE next cycle.
    task automatic finish_window(input vec_t v);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored_done", done4, 1);
        chk("start_ignored_counts", counts4, v.c4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_done", done4, 0);
        chk("reset_counts", counts4, 0);
        chk("reset_seconds_left", sl4, 3);
        chk("reset_tie", tie4, 0);
    endtask

    initial begin
        vec_t v;
        logic [63:0] r;

        tbl[0] = '{3'b000, pk(3'b011, 3'b000, 3'b011, 3'b000, 3'b010, 3'b000,
                              3'b010, 3'b100, 3'b010, 3'b000, 3'b000, 3'b000),
                   1'b0, 12'h152, 2'd1, 1'b0, 6'b01_11_10, 2'd1, 1'b0};
        tbl[1] = '{3'b001, pk(3'b011, 3'b001, 3'b011, 3'b001, 3'b011, 3'b001,
                              3'b011, 3'b001, 3'b011, 3'b001, 3'b011, 3'b001),
                   1'b0, 12'h060, 2'd1, 1'b0, 6'b00_11_00, 2'd1, 1'b0};
        tbl[2] = '{3'b000, pk(3'b100, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000,
                              3'b100, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000),
                   1'b1, 12'h500, 2'd2, 1'b0, 6'b11_00_00, 2'd2, 1'b0};
        tbl[3] = '{3'b000, pk(3'b111, 3'b000, 3'b111, 3'b000, 3'b111, 3'b000,
                              3'b110, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000),
                   1'b0, 12'h543, 2'd2, 1'b0, 6'b11_11_11, 2'd0, 1'b1};
        tbl[4] = '{3'b000, 36'h0, 1'b0, 12'h000, 2'd0, 1'b1, 6'b00_00_00, 2'd0, 1'b1};
        tbl[5] = '{3'b111, {12{3'b111}}, 1'b0, 12'h000, 2'd0, 1'b1, 6'b00_00_00, 2'd0, 1'b1};

        async_nreset = 1'b0;
        start = 1'b0;
        reset = 1'b0;
        btn   = 3'b000;
        tick();
        tick();
        chk("rst_counts", counts4, 0);
        chk("rst_winner", winner4, 0);
        chk("rst_tie", tie4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_seconds_left", sl4, 3);
        chk("rst_seconds_left_w2", sl2, 3);
        async_nreset = 1'b1;
        tick();

        // reset is ignored in IDLE
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("idle_reset_ignored", sl4, 3);

        for (int t = 0; t < 6; t++) begin
            win_id = t;
            run_window(tbl[t]);
            finish_window(tbl[t]);
        end

        // sync reset in the 6th counting cycle discards partial counts
        win_id = 100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            btn = (k % 2 == 0) ? 3'b111 : 3'b000;
            tick();
        end
        btn   = 3'b111;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        btn   = 3'b000;
        chk("abort_busy", busy4, 0);
        chk("abort_done", done4, 0);
        chk("abort_counts", counts4, 0);
        chk("abort_seconds_left", sl4, 3);
        tick();
        tick();
        chk("abort_stays_idle", busy4, 0);
        win_id = 101;
        run_window(tbl[0]);
        finish_window(tbl[0]);

        // async reset mid-COUNTING
        win_id = 102;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            btn = (k % 2 == 0) ? 3'b011 : 3'b000;
            tick();
        end
        chk("pre_async_busy", busy4, 1);
        #1 async_nreset = 1'b0;
        #1;
        chk("async_cnt_busy", busy4, 0);
        chk("async_cnt_seconds_left", sl4, 3);
        chk("async_cnt_done", done4, 0);
        #1 async_nreset = 1'b1;
        btn = 3'b000;
        tick();
        tick();
        chk("async_cnt_idle_after", busy4, 0);
        chk("async_cnt_sl_after", sl4, 3);

        // async reset mid-RESULT
        win_id = 103;
        run_window(tbl[3]);
        #1 async_nreset = 1'b0;
        #1;
        chk("async_res_done", done4, 0);
        chk("async_res_counts", counts4, 0);
        chk("async_res_counts_w2", counts2, 0);
        chk("async_res_winner", winner4, 0);
        chk("async_res_tie", tie4, 0);
        chk("async_res_seconds_left", sl4, 3);
        #1 async_nreset = 1'b1;
        tick();
        tick();
        chk("async_res_idle_after", done4, 0);
        chk("async_res_busy_after", busy4, 0);

        // randomized windows against the reference
        for (int t = 0; t < 20; t++) begin
            win_id = 200 + t;
            r = {$urandom(), $urandom()};
            v.pre = 3'($urandom_range(0, 7));
            v.seq = r[35:0];
            v.with_rst = 1'b0;
            model(v.pre, v.seq, 4, v.c4, v.w4, v.t4);
            begin
                logic [11:0] c2w;
                model(v.pre, v.seq, 2, c2w, v.w2, v.t2);
                v.c2 = narrow(c2w);
            end
            run_window(v);
            finish_window(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
